codificador_tx: RTL and testbench



---
 rtl/codificador_tx.sv | 182 ++++++++++++++++++
 tb/tb_codificador_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_tx.sv
// codificador_tx: one BCD record -> eight ASCII digit characters for the UART tx core.
// Define CODIFICADOR_CRLF_EN to append CR, LF after the digits (10-character frame).
module codificador_tx #(
  parameter logic [7:0] ASCII_BASE  = 8'h30,
  parameter int         ACK_TIMEOUT = 1023,
  parameter int         TO_W        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enviar,
  input  logic [11:0] humedad,
  input  logic [15:0] hora,
  input  logic [3:0]  tipoPlanta,
  input  logic        ocupado,
  output logic [7:0]  dato,
  output logic        iniciar,
  output logic        enviando,
  output logic        listo,
  output logic        error
);

`ifdef CODIFICADOR_CRLF_EN
  typedef enum logic [2:0] {
    IDLE, START, WAIT_ACK, WAIT_DONE, CR, LF
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, START, WAIT_ACK, WAIT_DONE
  } state_t;
`endif

  localparam logic [TO_W:0] LP_TO =
    (TO_W+1)'(ACK_TIMEOUT);

  state_t        r_state, w_state_nx;
  logic [31:0]   r_snap, w_snap_nx;
  logic [2:0]    r_idx, w_idx_nx;
  logic [TO_W-1:0] r_to, w_to_nx;
  logic [7:0]    r_dato, w_dato_nx;
  logic          r_env, w_env_nx;
  logic          r_listo, w_listo_nx;
  logic          r_err, w_err_nx;
  logic          w_ini;
  logic          w_last;
  logic [2:0]    w_idx_inc;
  logic [TO_W:0] w_to_inc;
  logic [31:0]   w_word;
`ifdef CODIFICADOR_CRLF_EN
  logic [1:0]    r_tail, w_tail_nx;
`endif

  // Digit idx sits at bits (7-idx)*4; non-BCD nibbles become '?'
  function automatic logic [7:0] f_char(
    input logic [31:0] word,
    input logic [2:0]  idx
  );
    logic [3:0] d;
    d = word[{~idx, 2'b00} +: 4];
    if (d > 4'd9) return 8'h3F;
    return ASCII_BASE + {4'h0, d};
  endfunction

  assign w_word    = {humedad, hora, tipoPlanta};
  assign w_idx_inc = r_idx + 3'd1;
  assign w_to_inc  = {1'b0, r_to} + (TO_W+1)'(1);

`ifdef CODIFICADOR_CRLF_EN
  assign w_last = (r_tail == 2'd2);
`else
  assign w_last = (r_idx == 3'd7);
`endif

  always_comb begin
    w_state_nx = r_state;
    w_snap_nx  = r_snap;
    w_idx_nx   = r_idx;
    w_to_nx    = r_to;
    w_dato_nx  = r_dato;
    w_env_nx   = r_env;
    w_listo_nx = 1'b0;
    w_err_nx   = 1'b0;
    w_ini      = 1'b0;
`ifdef CODIFICADOR_CRLF_EN
    w_tail_nx  = r_tail;
`endif
    unique case (r_state)
      IDLE: begin
        if (enviar && !ocupado) begin
          w_snap_nx  = w_word;
          w_idx_nx   = 3'd0;
          w_dato_nx  = f_char(w_word, 3'd0);
          w_env_nx   = 1'b1;
          w_state_nx = START;
`ifdef CODIFICADOR_CRLF_EN
          w_tail_nx  = 2'd0;
`endif
        end
      end
`ifdef CODIFICADOR_CRLF_EN
      START, CR, LF: begin
`else
      START: begin
`endif
        if (!ocupado) begin
          w_ini      = 1'b1;
          w_to_nx    = '0;
          w_state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ocupado) begin
          w_state_nx = WAIT_DONE;
        end else if (w_to_inc == LP_TO) begin
          w_err_nx   = 1'b1;
          w_env_nx   = 1'b0;
          w_state_nx = IDLE;
        end else begin
          w_to_nx = w_to_inc[TO_W-1:0];
        end
      end
      WAIT_DONE: begin
        if (!ocupado) begin
          if (w_last) begin
            w_listo_nx = 1'b1;
            w_env_nx   = 1'b0;
            w_state_nx = IDLE;
`ifdef CODIFICADOR_CRLF_EN
          end else if (r_tail == 2'd1) begin
            w_dato_nx  = 8'h0A;
            w_tail_nx  = 2'd2;
            w_state_nx = LF;
          end else if (r_idx == 3'd7) begin
            w_dato_nx  = 8'h0D;
            w_tail_nx  = 2'd1;
            w_state_nx = CR;
`endif
          end else begin
            w_idx_nx   = w_idx_inc;
            w_dato_nx  = f_char(r_snap, w_idx_inc);
            w_state_nx = START;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_snap  <= '0;
      r_idx   <= '0;
      r_to    <= '0;
      r_dato  <= 8'h00;
      r_env   <= 1'b0;
      r_listo <= 1'b0;
      r_err   <= 1'b0;
`ifdef CODIFICADOR_CRLF_EN
      r_tail  <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_snap  <= w_snap_nx;
      r_idx   <= w_idx_nx;
      r_to    <= w_to_nx;
      r_dato  <= w_dato_nx;
      r_env   <= w_env_nx;
      r_listo <= w_listo_nx;
      r_err   <= w_err_nx;
`ifdef CODIFICADOR_CRLF_EN
      r_tail  <= w_tail_nx;
`endif
    end
  end

  assign dato     = r_dato;
  assign iniciar  = w_ini;
  assign enviando = r_env;
  assign listo    = r_listo;
  assign error    = r_err;

endmodule

// File: tb/tb_codificador_tx.sv
// tb_codificador_tx: random and directed frames checked against a digit-level model.
// A small tx model answers iniciar with a busy pulse; monitors count strobes.
module tb_codificador_tx;
  localparam int ACK_TO = 1023;
`ifdef CODIFICADOR_CRLF_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 8;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enviar = 1'b0;
  logic [11:0] humedad = '0;
  logic [15:0] hora = '0;
  logic [3:0]  tipoPlanta = '0;
  logic        ocupado;
  logic [7:0]  dato;
  logic        iniciar, enviando, listo, error;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int tx_mode = 1;
  int n_ini = 0, n_listo = 0, n_err = 0;
  int n_rise = 0, n_bad = 0;
  bit env_prev = 1'b0;
  int ini_t[$];
  int err_t[$];
  int cap[$];
  int exp_q[$];

  codificador_tx dut (
    .clk(clk), .rst(rst), .enviar(enviar),
    .humedad(humedad), .hora(hora),
    .tipoPlanta(tipoPlanta), .ocupado(ocupado),
    .dato(dato), .iniciar(iniciar),
    .enviando(enviando), .listo(listo),
    .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // tx model: mode 0 never busy, 1 busy 2 cycles after iniciar for 10, 2 stuck busy
  initial begin
    ocupado = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_mode == 2) ocupado = 1'b1;
      else if (tx_mode == 0) ocupado = 1'b0;
      else if (iniciar) begin
        cap.push_back(int'(dato));
        repeat (2) @(posedge clk);
        #1 ocupado = 1'b1;
        repeat (10) @(posedge clk);
        #1 ocupado = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (iniciar) begin
      n_ini++;
      ini_t.push_back(cyc);
      if (!enviando) n_bad++;
    end
    if (listo) n_listo++;
    if (error) begin
      n_err++;
      err_t.push_back(cyc);
    end
    if (listo && (error || enviando)) n_bad++;
    if (enviando && !env_prev) n_rise++;
    env_prev = enviando;
  end

  function automatic void build_exp(
    input logic [11:0] h, input logic [15:0] hr,
    input logic [3:0] t
  );
    int dg[8];
    exp_q.delete();
    dg[0] = int'(h) / 256;
    dg[1] = (int'(h) / 16) % 16;
    dg[2] = int'(h) % 16;
    dg[3] = int'(hr) / 4096;
    dg[4] = (int'(hr) / 256) % 16;
    dg[5] = (int'(hr) / 16) % 16;
    dg[6] = int'(hr) % 16;
    dg[7] = int'(t);
    foreach (dg[i])
      exp_q.push_back(dg[i] < 10 ? 48 + dg[i] : 63);
`ifdef CODIFICADOR_CRLF_EN
    exp_q.push_back(13);
    exp_q.push_back(10);
`endif
  endfunction

  task automatic send_frame(
    input logic [11:0] h, input logic [15:0] hr,
    input logic [3:0] t, input bit scramble,
    input int hold, input string nm
  );
    int bi, bc, bl, be, br, bb, tacc, got, lat;
    bi = n_ini; bc = cap.size(); bl = n_listo;
    be = n_err; br = n_rise; bb = n_bad;
    build_exp(h, hr, t);
    @(posedge clk); #1;
    humedad = h; hora = hr; tipoPlanta = t;
    enviar = 1'b1;
    @(posedge clk); #1;
    tacc = cyc;
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
    end
    enviar = 1'b0;
    if (scramble) begin
      @(posedge clk); #1;
      humedad = 12'h999; hora = 16'h9999;
      tipoPlanta = 4'h9;
    end
    for (int c = 0; c < 600 && n_listo == bl && n_err == be; c++)
      @(negedge clk);
    repeat (20) @(negedge clk);
    n_chk++;
    if (n_listo - bl !== 1)
      $display("FAIL %s listo: got %0d want 1", nm, n_listo - bl);
    else n_pass++;
    n_chk++;
    if (n_err - be !== 0)
      $display("FAIL %s error: got %0d want 0", nm, n_err - be);
    else n_pass++;
    n_chk++;
    if (n_ini - bi !== FLEN)
      $display("FAIL %s iniciar count: got %0d want %0d", nm, n_ini - bi, FLEN);
    else n_pass++;
    for (int i = 0; i < FLEN; i++) begin
      got = (bc + i < cap.size()) ? cap[bc + i] : -1;
      n_chk++;
      if (got !== exp_q[i])
        $display("FAIL %s char%0d: got %0h want %0h", nm, i, got, exp_q[i]);
      else n_pass++;
    end
    lat = (ini_t.size() > bi) ? ini_t[bi] : -1;
    n_chk++;
    if (lat !== tacc)
      $display("FAIL %s first iniciar cycle: got %0d want %0d", nm, lat, tacc);
    else n_pass++;
    n_chk++;
    if (n_rise - br !== 1 || n_bad - bb !== 0)
      $display("FAIL %s enviando: rises %0d bad %0d want 1 0", nm, n_rise - br, n_bad - bb);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (dato !== 8'h00) $display("FAIL reset dato: got %0h want 0", dato);
    else n_pass++;
    n_chk++;
    if ({iniciar, enviando, listo, error} !== 4'b0)
      $display("FAIL reset strobes: got %b want 0000", {iniciar, enviando, listo, error});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    send_frame(12'h045, 16'h1330, 4'h2, 1'b0, 1, "basic");
  endtask

  task automatic test_snapshot();
    send_frame(12'h045, 16'h1330, 4'h2, 1'b1, 1, "snapshot");
  endtask

  task automatic test_invalid_digit();
    send_frame(12'h0A0, 16'h1330, 4'hB, 1'b0, 1, "invalid");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++)
      send_frame(12'($urandom_range(0, 4095)),
                 16'($urandom_range(0, 65535)),
                 4'($urandom_range(0, 15)), 1'b0, 1, "random");
  endtask

  task automatic test_busy_ignore();
    int bi;
    tx_mode = 2;
    repeat (2) @(posedge clk);
    bi = n_ini;
    #1 enviar = 1'b1;
    @(posedge clk); #1 enviar = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (n_ini - bi !== 0 || enviando !== 1'b0)
      $display("FAIL busy_ignore: iniciar %0d enviando %b want 0 0", n_ini - bi, enviando);
    else n_pass++;
    tx_mode = 0;
    repeat (3) @(posedge clk);
    tx_mode = 1;
  endtask

  task automatic test_timeout();
    int bi, bl, be, dt;
    tx_mode = 0;
    bi = n_ini; bl = n_listo; be = n_err;
    @(posedge clk); #1 enviar = 1'b1;
    @(posedge clk); #1 enviar = 1'b0;
    for (int c = 0; c < ACK_TO + 100 && n_err == be; c++)
      @(negedge clk);
    n_chk++;
    if (n_err - be !== 1 || n_listo - bl !== 0)
      $display("FAIL timeout pulses: error %0d listo %0d want 1 0", n_err - be, n_listo - bl);
    else n_pass++;
    n_chk++;
    if (n_ini - bi !== 1)
      $display("FAIL timeout iniciar: got %0d want 1", n_ini - bi);
    else n_pass++;
    dt = (err_t.size() > be && ini_t.size() > bi) ? err_t[be] - ini_t[bi] : -1;
    n_chk++;
    if (dt !== ACK_TO + 1)
      $display("FAIL timeout delay: got %0d want %0d", dt, ACK_TO + 1);
    else n_pass++;
    n_chk++;
    if (enviando !== 1'b0)
      $display("FAIL timeout enviando: got %b want 0", enviando);
    else n_pass++;
    tx_mode = 1;
    repeat (2) @(posedge clk);
    send_frame(12'h321, 16'h0759, 4'h4, 1'b0, 1, "after_timeout");
  endtask

  task automatic test_reset_mid();
    int bi, bl, be;
    bit hit;
    bi = n_ini; bl = n_listo; be = n_err;
    hit = 1'b0;
    @(posedge clk); #1;
    humedad = 12'h678; hora = 16'h2145; tipoPlanta = 4'h1;
    enviar = 1'b1;
    @(posedge clk); #1 enviar = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (n_ini - bi == 4) && ocupado;
    end
    n_chk++;
    if (!hit) $display("FAIL reset_mid reach: got 0 want 1");
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({dato, iniciar, enviando, listo, error} !== 12'h0)
      $display("FAIL reset_mid outputs: got %0h want 0", {dato, iniciar, enviando, listo, error});
    else n_pass++;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_chk++;
    if (n_ini - bi !== 4 || n_listo - bl !== 0 || n_err - be !== 0)
      $display("FAIL reset_mid after: iniciar %0d listo %0d error %0d want 4 0 0",
               n_ini - bi, n_listo - bl, n_err - be);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send_frame(12'h999, 16'h2359, 4'h7, 1'b0, 3, "enviar_held");
    send_frame(12'h100, 16'h0001, 4'h0, 1'b0, 1, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_invalid_digit();
    test_busy_ignore();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
